// File: rtl/adder_arbiter_16b_if.sv
// Request/grant/result bundle shared by two add requesters and the nibble-serial adder.
interface adder_arbiter_16b_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         cin0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic         owner;
    logic [W-1:0] s;
    logic         cout;

    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1,
        input  gnt0, gnt1, busy, done, owner, s, cout
    );

    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1,
        output gnt0, gnt1, busy, done, owner, s, cout
    );
endinterface

// File: rtl/adder_arbiter_16b.sv
// Two-requester round-robin arbiter in front of a nibble-serial ripple adder.
// One 4-bit slice is added per cycle; the result is published in the FIN cycle.
module adder_arbiter_16b #(
    parameter int NIBBLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    adder_arbiter_16b_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic          ptr;
    logic          win;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  work;
    logic          carry;

    logic [4:0]    slice;
    logic [W-1:0]  work_next;
    logic          pick1;

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign pick1 = bus.req1 && (!bus.req0 || ptr);

    always_comb begin
        slice     = {1'b0, op_a[4*k +: 4]} + {1'b0, op_b[4*k +: 4]} + {4'b0, carry};
        work_next = work;
        work_next[4*k +: 4] = slice[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            ptr      <= 1'b0;
            win      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            work     <= '0;
            carry    <= 1'b0;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.owner <= 1'b0;
            bus.s     <= '0;
            bus.cout  <= 1'b0;
        end else begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        // Carry register doubles as the captured carry-in for slice 0.
                        op_a     <= pick1 ? bus.a1 : bus.a0;
                        op_b     <= pick1 ? bus.b1 : bus.b0;
                        carry    <= pick1 ? bus.cin1 : bus.cin0;
                        win      <= pick1;
                        ptr      <= !pick1;
                        k        <= '0;
                        bus.gnt0 <= !pick1;
                        bus.gnt1 <= pick1;
                        bus.busy <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    work  <= work_next;
                    carry <= slice[4];
                    if (k == K_LAST) begin
                        bus.s     <= work_next;
                        bus.cout  <= slice[4];
                        bus.owner <= win;
                        bus.done  <= 1'b1;
                        state     <= FIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter_16b.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops them on DONE.
module tb_adder_arbiter_16b;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    typedef struct {
        logic        owner;
        logic [15:0] s;
        logic        cout;
    } exp_t;
    exp_t q[$];

    int last_gnt_cyc  = -100;
    int last_done_cyc = -100;
    logic last_gnt_who = 1'b0;

    adder_arbiter_16b_if #(.NIBBLES(4)) bus ();

    adder_arbiter_16b #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic owner, input logic [15:0] s, input logic cout);
        exp_t e;
        e.owner = owner;
        e.s     = s;
        e.cout  = cout;
        q.push_back(e);
    endtask

    // Monitor: grant bookkeeping and result checking against the queue
    always @(negedge clk) begin
        if (!rst && (bus.gnt0 || bus.gnt1)) begin
            last_gnt_cyc = cyc;
            last_gnt_who = bus.gnt1;
        end
        if (!rst && bus.done) begin
            last_done_cyc = cyc;
            check("done_latency", cyc - last_gnt_cyc, 4);
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("owner", bus.owner, e.owner);
                check("owner_vs_gnt", bus.owner, last_gnt_who);
                check("sum", bus.s, e.s);
                check("cout", bus.cout, e.cout);
            end
        end
    end

    task automatic wait_gnt(output int gc, output logic who);
        gc  = -1;
        who = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                gc  = cyc;
                who = bus.gnt1;
                return;
            end
        end
        check("gnt_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.busy) return;
        end
        check("idle_timeout", 1, 0);
    endtask

    initial begin
        int   g0, g1, g2, h;
        int   rel;
        logic w;
        logic activity;

        rst = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 16'h1234; bus.b0 = 16'h4321; bus.cin0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 16'h8000; bus.b1 = 16'h8000; bus.cin1 = 1'b0;
        push_exp(1'b0, 16'h5555, 1'b0);
        push_exp(1'b1, 16'h0000, 1'b1);
        push_exp(1'b0, 16'h5555, 1'b0);

        // Reset held with both requests high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_s", bus.s, 0);
        check("rst_cout", bus.cout, 0);
        rel = cyc;
        rst = 1'b0;

        // Both held: alternating grants six cycles apart
        wait_gnt(g0, w);
        check("first_gnt_who", w, 0);
        check("first_gnt_delay", g0 - rel, 1);
        check("first_busy", bus.busy, 1);
        wait_gnt(g1, w);
        check("rr_gnt2_who", w, 1);
        check("rr_gnt2_gap", g1 - g0, 6);
        wait_gnt(g2, w);
        check("rr_gnt3_who", w, 0);
        check("rr_gnt3_gap", g2 - g1, 6);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_idle();

        // Requester 1 alone, full ripple; operands disturbed after grant
        bus.a1 = 16'hFFFF; bus.b1 = 16'h0000; bus.cin1 = 1'b1;
        push_exp(1'b1, 16'h0000, 1'b1);
        bus.req1 = 1'b1;
        wait_gnt(h, w);
        check("r1_only_who", w, 1);
        bus.req1 = 1'b0;
        bus.a1 = 16'h1234; bus.cin1 = 1'b0;
        wait_idle();

        // Requester 1 arrives during a requester-0 operation
        bus.a0 = 16'h00FF; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
        push_exp(1'b0, 16'h0100, 1'b0);
        bus.req0 = 1'b1;
        wait_gnt(g0, w);
        check("late_r0_who", w, 0);
        bus.req0 = 1'b0;
        bus.a0 = 16'h0000;
        @(negedge clk);
        bus.a1 = 16'h7FFF; bus.b1 = 16'h0001; bus.cin1 = 1'b1;
        push_exp(1'b1, 16'h8001, 1'b0);
        bus.req1 = 1'b1;
        wait_gnt(h, w);
        check("late_r1_who", w, 1);
        check("late_r1_gap", h - g0, 6);
        check("late_r1_after_done", h - last_done_cyc, 2);
        bus.req1 = 1'b0;
        bus.a1 = 16'hFFFF;
        wait_idle();

        // Establish S=0x5555, then abort the next operation with reset
        bus.a0 = 16'h1234; bus.b0 = 16'h4321; bus.cin0 = 1'b0;
        push_exp(1'b0, 16'h5555, 1'b0);
        bus.req0 = 1'b1;
        wait_gnt(h, w);
        bus.req0 = 1'b0;
        wait_idle();
        check("pre_abort_s", bus.s, 16'h5555);
        bus.a0 = 16'h1111; bus.b0 = 16'h0001;
        bus.req0 = 1'b1;
        wait_gnt(h, w);
        bus.req0 = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_s", bus.s, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        activity = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy || bus.gnt0 || bus.gnt1 || bus.done) activity = 1'b1;
        end
        check("idle_after_abort", activity, 0);
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_arbiter_16b.md
ADDER_ARBITER_16B -- requirements
Module: adder_arbiter_16b

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand. Operand width W = 4*NIBBLES.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 REQ0  input  1  requester 0 add request, level; held high until GNT0.
REQ-005 A0, B0  input  W  requester 0 operands.
REQ-006 Cin0  input  1  requester 0 carry-in.
REQ-007 REQ1, A1, B1, Cin1  input  1/W/W/1  requester 1 equivalents of REQ-004..006.
REQ-008 GNT0, GNT1  output  1  one-cycle grant pulse; operands are captured on the same edge that raises it.
REQ-009 BUSY  output  1  high while an operation is in progress.
REQ-010 DONE  output  1  one-cycle pulse; result valid.
REQ-011 OWNER  output  1  index of the requester that owns S/Cout.
REQ-012 S  output  W  sum; Cout  output  1  carry-out.

Function
REQ-013 States: IDLE, ADD, FIN; all outputs registered.
REQ-014 IDLE: if REQ0 or REQ1 is sampled high at an edge, the controller captures the winner's A, B, Cin, clears the slice index k to 0, and enters ADD.
- The winner's GNT and BUSY are high in the following cycle.
REQ-015 Arbitration is round-robin with a 1-bit priority pointer.
- Single requester: that requester wins.
- Both requesting: the pointer's requester wins.
- After any grant, the pointer moves to the other requester.
REQ-016 ADD: each cycle processes one 4-bit slice, k = 0..NIBBLES-1.
- Slice sum: A[4k+3:4k] + B[4k+3:4k] + c, where c is the captured Cin for k=0 and the registered slice carry otherwise.
- The slice sum is written to working-register bits [4k+3:4k].
REQ-017 ADD lasts exactly NIBBLES cycles, then FIN. GNT is high only in the first ADD cycle.
REQ-018 FIN, one cycle:
- DONE=1, BUSY=1.
- S loads the working register, Cout loads the final slice carry, OWNER loads the granted index.
- Next state is IDLE.
REQ-019 Latency: DONE is asserted exactly NIBBLES cycles after the GNT cycle. The result equals the W-bit sum A+B+Cin with carry-out.
REQ-020 S, Cout and OWNER hold their value until the next FIN. They are never updated during IDLE or ADD.
REQ-021 REQ0/REQ1 are ignored in ADD and FIN. A request pending then is evaluated at the first IDLE edge.
- Back-to-back issue interval is NIBBLES+2 cycles.
REQ-022 Operand inputs may change after GNT without affecting the operation in progress.

Reset
REQ-023 While RST is high, regardless of clock:
- State=IDLE, k=0, priority pointer=0 (requester 0 favoured).
- GNT0=GNT1=BUSY=DONE=OWNER=Cout=0, S=0, working register and slice carry=0.
REQ-024 Reset during ADD or FIN aborts the operation. No DONE is produced for it, and S/Cout return to 0.
REQ-025 After RST deasserts, the first possible grant is on the first rising edge at which a REQ is sampled high.

Verification
REQ-026 Reset with REQ0=REQ1=1 held -> all outputs 0 while RST=1; GNT0 pulses one cycle after release.
REQ-027 REQ0 only, A0=0x1234, B0=0x4321, Cin0=0 -> GNT0 one cycle; DONE 4 cycles later; S=0x5555, Cout=0, OWNER=0.
REQ-028 REQ1 only, A1=0xFFFF, B1=0x0000, Cin1=1 -> full ripple; S=0x0000, Cout=1, OWNER=1.
REQ-029 REQ0 and REQ1 held high continuously -> grants alternate GNT0, GNT1, GNT0.
- Consecutive grants are 6 cycles apart.
- Each DONE carries the matching OWNER and sum, e.g. A1=0x8000, B1=0x8000 -> S=0x0000, Cout=1.
REQ-030 REQ1 raised in the second ADD cycle of a requester-0 operation -> no GNT1 until after DONE. GNT1 follows DONE by exactly 2 cycles.
REQ-031 RST pulsed during the 2nd ADD cycle, with S holding 0x5555 from a prior op -> BUSY and S drop to 0 immediately, no DONE; after release with no REQ the block stays IDLE.
